lsu_cluster: RTL and testbench
==============================

# lsu_cluster

Per-thread load/store unit array for one compute core. It answers the core FSM's memory phase: on the core's REQUEST state each enabled lane issues one read or write to the memory controller over a valid/ready channel, and reports its progress on `lsu_state_all`. The core sequencer holds in WAIT until no lane reports REQUESTING or WAITING. Loaded data is returned per lane to the register-file writeback path.

## Interface
- `THREADS`, 4, number of lanes (one per thread)
- `ADDR_W`, 8, memory address width
- `DATA_W`, 8, memory data width
- `clk  in  1  clock`
- `reset  in  1  asynchronous, active-high`
- `thread_enable  in  THREADS  lane i participates when bit i = 1`
- `core_state  in  3  core sequencer state (IDLE=0 … UPDATE=6, DONE=7)`
- `decoded_mem_read_enable  in  1  current instruction is LDR`
- `decoded_mem_write_enable  in  1  current instruction is STR`
- `rs_all  in  THREADS*DATA_W  per-lane address operand, lane i at [i*DATA_W +: DATA_W]`; low ADDR_W bits used
- `rt_all  in  THREADS*DATA_W  per-lane store data`
- `mem_read_valid  out  THREADS  per-lane read request`
- `mem_read_address  out  THREADS*ADDR_W  per-lane read address`
- `mem_read_ready  in  THREADS  read accepted, data valid this cycle`
- `mem_read_data  in  THREADS*DATA_W  read return data`
- `mem_write_valid  out  THREADS  per-lane write request`
- `mem_write_address  out  THREADS*ADDR_W  per-lane write address`
- `mem_write_data  out  THREADS*DATA_W  per-lane write data`
- `mem_write_ready  in  THREADS  write accepted`
- `lsu_state_all  out  2*THREADS  lane i state at [2i+1:2i]`
- `lsu_out_all  out  THREADS*DATA_W  last loaded value per lane`

## Operation
- Lane states: IDLE=2'b00, REQUESTING=2'b01, WAITING=2'b10, DONE=2'b11. Lanes are fully independent.
- IDLE: if `thread_enable[i]` and `core_state==REQUEST (3'b011)` and read or write enable → REQUESTING; load valid, address (= rs[ADDR_W-1:0]) and write data (= rt) registers on the same edge. Otherwise stay.
- Read and write both asserted: read wins; write channel untouched.
- REQUESTING: valid held. If ready this cycle → DONE; else → WAITING.
- WAITING: valid, address, data held stable until ready. On ready → DONE.
- Completion edge (valid && ready): clear valid; for reads capture `mem_read_data` lane slice into `lsu_out` lane slice.
- DONE: hold until `core_state==UPDATE (3'b110)`, then → IDLE.
- Disabled lane: remains IDLE, never asserts valid; an enable dropping mid-transaction does not abort it.
- `lsu_out` retains its value until the next completed read on that lane; writes do not alter it.
- `mem_*_ready` while the corresponding valid is low: ignored.

## Timing
- Reset (async): all states IDLE, all valids 0, all addresses/data 0, `lsu_out_all` 0.
- Reset mid-transaction: valids drop immediately (not at next edge); memory controller must tolerate aborted requests.
- Valid rises on the edge where the core leaves REQUEST, so the core's first WAIT cycle already sees 01.
- Minimum latency: request edge → valid high; ready in that cycle → DONE and data captured one edge later (2 edges total).
- Each additional cycle of ready-low adds one cycle in WAITING; no timeout.
- All outputs registered; no combinational path from `mem_*_ready` to any output.

## Structure
- Shared package `gpu_pkg`: core-state localparams (IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, DONE) and LSU state encodings; `core_fsm` and this block both use them.
- Sub-module `lsu_lane` (one lane, scalar widths) instantiated THREADS times by generate loop; `lsu_cluster` only slices buses.

## Test plan
- Single read: lane0 enabled, rs=8'h2A, core_state=REQUEST for one cycle; ready held low 3 cycles then high with data 8'h5C → address 8'h2A, state 01,10,10,10,11, `lsu_out[7:0]`=8'h5C, valid low after completion.
- Write with ready in first cycle: rs=8'h10, rt=8'hAB → write valid one cycle, address 8'h10, data 8'hAB, state 01→11, `lsu_out` unchanged.
- All four lanes read, readies staggered at cycles 1,2,5,3 → each lane reaches 11 independently; `lsu_state_all` contains no 01/10 only after the fourth completion; UPDATE returns all to 00.
- thread_enable=4'b0101 → lanes 1,3 stay 00 with valids low; lanes 0,2 complete normally.
- Reset asserted while lane in WAITING → valid and state 00 without a clock edge; later transaction starts cleanly.
- Read and write enable both high → only read channel asserts.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared core definitions: core sequencer state codes and LSU lane state encoding.
// Used by the core FSM and the load/store unit cluster.
package gpu_pkg;

  localparam logic [2:0] CoreIdle    = 3'd0;
  localparam logic [2:0] CoreFetch   = 3'd1;
  localparam logic [2:0] CoreDecode  = 3'd2;
  localparam logic [2:0] CoreRequest = 3'd3;
  localparam logic [2:0] CoreWait    = 3'd4;
  localparam logic [2:0] CoreExecute = 3'd5;
  localparam logic [2:0] CoreUpdate  = 3'd6;
  localparam logic [2:0] CoreDone    = 3'd7;

  typedef enum logic [1:0] {
    LsuIdle       = 2'b00,
    LsuRequesting = 2'b01,
    LsuWaiting    = 2'b10,
    LsuDone       = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane.sv
// One load/store lane: issues a single read or write per core memory phase over a
// valid/ready channel and keeps the last loaded value for register writeback.
module lsu_lane
  import gpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        core_state,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  output logic              read_valid,
  output logic [ADDR_W-1:0] read_address,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] read_data,
  output logic              write_valid,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  input  logic              write_ready,
  output lsu_state_e        state,
  output logic [DATA_W-1:0] lsu_out
);

  lsu_state_e        state_q, state_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              accepted;

  // Ready is only meaningful while the matching valid is high.
  assign accepted = (rd_valid_q & read_ready) | (wr_valid_q & write_ready);

  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    wr_valid_d = wr_valid_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    out_d      = out_q;
    unique case (state_q)
      LsuIdle: begin
        if (enable && (core_state == CoreRequest) && (mem_read_enable || mem_write_enable)) begin
          state_d = LsuRequesting;
          if (mem_read_enable) begin
            rd_valid_d = 1'b1;
            rd_addr_d  = rs[ADDR_W-1:0];
          end else begin
            wr_valid_d = 1'b1;
            wr_addr_d  = rs[ADDR_W-1:0];
            wr_data_d  = rt;
          end
        end
      end
      LsuRequesting, LsuWaiting: begin
        if (accepted) begin
          state_d    = LsuDone;
          rd_valid_d = 1'b0;
          wr_valid_d = 1'b0;
          if (rd_valid_q) out_d = read_data;
        end else begin
          state_d = LsuWaiting;
        end
      end
      LsuDone: begin
        if (core_state == CoreUpdate) state_d = LsuIdle;
      end
      default: state_d = LsuIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LsuIdle;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      wr_valid_q <= wr_valid_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      out_q      <= out_d;
    end
  end

  assign read_valid    = rd_valid_q;
  assign read_address  = rd_addr_q;
  assign write_valid   = wr_valid_q;
  assign write_address = wr_addr_q;
  assign write_data    = wr_data_q;
  assign state         = state_q;
  assign lsu_out       = out_q;

endmodule

// File: rtl/lsu_cluster.sv
// Array of independent load/store lanes, one per thread; this level only slices the
// flattened per-lane buses.
module lsu_cluster
  import gpu_pkg::*;
#(
  parameter int unsigned THREADS = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [THREADS-1:0]          thread_enable,
  input  logic [2:0]                  core_state,
  input  logic                        decoded_mem_read_enable,
  input  logic                        decoded_mem_write_enable,
  input  logic [THREADS*DATA_W-1:0]   rs_all,
  input  logic [THREADS*DATA_W-1:0]   rt_all,
  output logic [THREADS-1:0]          mem_read_valid,
  output logic [THREADS*ADDR_W-1:0]   mem_read_address,
  input  logic [THREADS-1:0]          mem_read_ready,
  input  logic [THREADS*DATA_W-1:0]   mem_read_data,
  output logic [THREADS-1:0]          mem_write_valid,
  output logic [THREADS*ADDR_W-1:0]   mem_write_address,
  output logic [THREADS*DATA_W-1:0]   mem_write_data,
  input  logic [THREADS-1:0]          mem_write_ready,
  output logic [2*THREADS-1:0]        lsu_state_all,
  output logic [THREADS*DATA_W-1:0]   lsu_out_all
);

  for (genvar i = 0; i < THREADS; i++) begin : g_lane
    lsu_state_e lane_state;

    lsu_lane #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_lane (
      .clk              (clk),
      .reset            (reset),
      .enable           (thread_enable[i]),
      .core_state       (core_state),
      .mem_read_enable  (decoded_mem_read_enable),
      .mem_write_enable (decoded_mem_write_enable),
      .rs               (rs_all[i*DATA_W +: DATA_W]),
      .rt               (rt_all[i*DATA_W +: DATA_W]),
      .read_valid       (mem_read_valid[i]),
      .read_address     (mem_read_address[i*ADDR_W +: ADDR_W]),
      .read_ready       (mem_read_ready[i]),
      .read_data        (mem_read_data[i*DATA_W +: DATA_W]),
      .write_valid      (mem_write_valid[i]),
      .write_address    (mem_write_address[i*ADDR_W +: ADDR_W]),
      .write_data       (mem_write_data[i*DATA_W +: DATA_W]),
      .write_ready      (mem_write_ready[i]),
      .state            (lane_state),
      .lsu_out          (lsu_out_all[i*DATA_W +: DATA_W])
    );

    assign lsu_state_all[2*i +: 2] = lane_state;
  end

endmodule

// File: tb/tb_lsu_cluster.sv
// Directed bench for lsu_cluster: a per-lane memory responder pops expected requests from
// a scoreboard as each handshake is granted; the main sequence checks lane states and outputs.
module tb_lsu_cluster;

  localparam int T = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [T-1:0]  thread_enable = '0;
  logic [2:0]    core_state = 3'd0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [31:0]   rs_all = '0;
  logic [31:0]   rt_all = '0;
  logic [T-1:0]  mem_read_valid;
  logic [31:0]   mem_read_address;
  logic [T-1:0]  mem_read_ready = '0;
  logic [31:0]   mem_read_data = '0;
  logic [T-1:0]  mem_write_valid;
  logic [31:0]   mem_write_address;
  logic [31:0]   mem_write_data;
  logic [T-1:0]  mem_write_ready = '0;
  logic [7:0]    lsu_state_all;
  logic [31:0]   lsu_out_all;

  lsu_cluster #(.THREADS(T), .ADDR_W(8), .DATA_W(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .thread_enable            (thread_enable),
    .core_state               (core_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .rs_all                   (rs_all),
    .rt_all                   (rt_all),
    .mem_read_valid           (mem_read_valid),
    .mem_read_address         (mem_read_address),
    .mem_read_ready           (mem_read_ready),
    .mem_read_data            (mem_read_data),
    .mem_write_valid          (mem_write_valid),
    .mem_write_address        (mem_write_address),
    .mem_write_data           (mem_write_data),
    .mem_write_ready          (mem_write_ready),
    .lsu_state_all            (lsu_state_all),
    .lsu_out_all              (lsu_out_all)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lane;
    bit         is_read;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   dly [T] = '{1, 1, 1, 1};
  int   vcnt[T] = '{0, 0, 0, 0};
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: grants lane i on the dly[i]-th cycle its valid is seen high.
  always @(negedge clk) begin
    int   idx;
    exp_t e;
    for (int i = 0; i < T; i++) begin
      mem_read_ready[i]  = 1'b0;
      mem_write_ready[i] = 1'b0;
      if (mem_read_valid[i] || mem_write_valid[i]) begin
        if (vcnt[i] + 1 == dly[i]) begin
          vcnt[i] = 0;
          idx = -1;
          for (int k = 0; k < sb.size(); k++) if (idx < 0 && sb[k].lane == i) idx = k;
          check($sformatf("sb_has_entry_lane%0d", i), {31'd0, idx >= 0}, 32'd1);
          if (idx >= 0) begin
            e = sb[idx];
            sb.delete(idx);
            check($sformatf("kind_lane%0d", i), {30'd0, mem_read_valid[i], mem_write_valid[i]},
                  e.is_read ? 32'd2 : 32'd1);
            if (e.is_read) begin
              check($sformatf("rd_addr_lane%0d", i), {24'd0, mem_read_address[i*8 +: 8]},
                    {24'd0, e.addr});
              mem_read_data[i*8 +: 8] = e.data;
              mem_read_ready[i] = 1'b1;
            end else begin
              check($sformatf("wr_addr_lane%0d", i), {24'd0, mem_write_address[i*8 +: 8]},
                    {24'd0, e.addr});
              check($sformatf("wr_data_lane%0d", i), {24'd0, mem_write_data[i*8 +: 8]},
                    {24'd0, e.data});
              mem_write_ready[i] = 1'b1;
            end
          end
        end else begin
          vcnt[i] = vcnt[i] + 1;
        end
      end else begin
        vcnt[i] = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int lane, input bit is_read, input logic [7:0] a,
                      input logic [7:0] d);
    exp_t e;
    e.lane = lane; e.is_read = is_read; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic update_phase();
    core_state = 3'd6;
    step();
    core_state = 3'd0;
    check("update_to_idle", {24'd0, lsu_state_all}, 32'd0);
  endtask

  logic [1:0] exp_st;
  logic [7:0] exp_all;
  int         d3[T] = '{1, 2, 5, 3};

  initial begin
    // Reset state
    #12;
    check("rst_state", {24'd0, lsu_state_all}, 32'd0);
    check("rst_valids", {24'd0, mem_read_valid, mem_write_valid}, 32'd0);
    check("rst_out", lsu_out_all, 32'd0);
    check("rst_addr", mem_read_address | mem_write_address | mem_write_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Single read, ready on 4th valid cycle
    thread_enable = 4'b0001; rd_en = 1'b1; rs_all = 32'h0000_002A; core_state = 3'd3;
    dly[0] = 4; push(0, 1'b1, 8'h2A, 8'h5C);
    step();
    core_state = 3'd4;
    check("rd_state_req", {30'd0, lsu_state_all[1:0]}, 32'h1);
    check("rd_valid", {28'd0, mem_read_valid}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rd_state_wait", {30'd0, lsu_state_all[1:0]}, 32'h2);
    end
    step();
    check("rd_state_done", {30'd0, lsu_state_all[1:0]}, 32'h3);
    check("rd_out", lsu_out_all, 32'h0000_005C);
    check("rd_valid_low", {28'd0, mem_read_valid}, 32'h0);
    rd_en = 1'b0;
    update_phase();

    // Write accepted in its first cycle
    wr_en = 1'b1; rs_all = 32'h0000_0010; rt_all = 32'h0000_00AB; core_state = 3'd3;
    dly[0] = 1; push(0, 1'b0, 8'h10, 8'hAB);
    step();
    core_state = 3'd4;
    check("wr_state_req", {30'd0, lsu_state_all[1:0]}, 32'h1);
    check("wr_valid", {24'd0, mem_write_valid, mem_read_valid}, 32'h10);
    step();
    check("wr_state_done", {30'd0, lsu_state_all[1:0]}, 32'h3);
    check("wr_valid_low", {28'd0, mem_write_valid}, 32'h0);
    check("wr_out_kept", lsu_out_all, 32'h0000_005C);
    wr_en = 1'b0;
    update_phase();

    // Four lanes, staggered readies
    thread_enable = 4'b1111; rd_en = 1'b1; rs_all = 32'h4433_2211; core_state = 3'd3;
    for (int i = 0; i < T; i++) begin
      dly[i] = d3[i];
      push(i, 1'b1, 8'h11 * (i + 1), 8'hA0 + 8'(i));
    end
    step();
    core_state = 3'd4;
    check("all_req", {24'd0, lsu_state_all}, 32'h55);
    for (int k = 1; k <= 5; k++) begin
      step();
      exp_all = '0;
      for (int i = 0; i < T; i++) begin
        exp_st = (k >= d3[i]) ? 2'b11 : 2'b10;
        exp_all[2*i +: 2] = exp_st;
      end
      check($sformatf("all_state_k%0d", k), {24'd0, lsu_state_all}, {24'd0, exp_all});
    end
    check("all_out", lsu_out_all, 32'hA3A2_A1A0);
    rd_en = 1'b0;
    update_phase();

    // Lanes 1 and 3 disabled
    thread_enable = 4'b0101; rd_en = 1'b1; rs_all = 32'h0403_0201; core_state = 3'd3;
    dly[0] = 2; dly[2] = 1;
    push(0, 1'b1, 8'h01, 8'hC0);
    push(2, 1'b1, 8'h03, 8'hC2);
    step();
    core_state = 3'd4;
    check("en_req", {24'd0, lsu_state_all}, 32'h11);
    check("en_valids", {24'd0, mem_read_valid, mem_write_valid}, 32'h50);
    step();
    check("en_mid", {24'd0, lsu_state_all}, 32'h32);
    step();
    check("en_done", {24'd0, lsu_state_all}, 32'h33);
    check("en_out", lsu_out_all, 32'hA3C2_A1C0);
    rd_en = 1'b0;
    update_phase();

    // Async reset while waiting
    thread_enable = 4'b0001; rd_en = 1'b1; rs_all = 32'h0000_0099; core_state = 3'd3;
    dly[0] = 50; push(0, 1'b1, 8'h99, 8'hEE);
    step();
    core_state = 3'd4;
    step();
    check("rst_mid_wait", {30'd0, lsu_state_all[1:0]}, 32'h2);
    reset = 1'b1;
    #1;
    check("rst_mid_state", {24'd0, lsu_state_all}, 32'h0);
    check("rst_mid_valid", {28'd0, mem_read_valid}, 32'h0);
    check("rst_mid_out", lsu_out_all, 32'h0);
    sb.delete();
    core_state = 3'd0;
    step();
    reset = 1'b0;
    step();
    rs_all = 32'h0000_0042; core_state = 3'd3; dly[0] = 1; push(0, 1'b1, 8'h42, 8'h77);
    step();
    core_state = 3'd4;
    check("post_rst_req", {30'd0, lsu_state_all[1:0]}, 32'h1);
    step();
    check("post_rst_done", {30'd0, lsu_state_all[1:0]}, 32'h3);
    check("post_rst_out", lsu_out_all, 32'h0000_0077);
    update_phase();

    // Read and write both enabled: read wins
    wr_en = 1'b1; rs_all = 32'h0000_0033; rt_all = 32'h0000_0044; core_state = 3'd3;
    dly[0] = 1; push(0, 1'b1, 8'h33, 8'h5A);
    step();
    core_state = 3'd4;
    check("both_valids", {24'd0, mem_read_valid, mem_write_valid}, 32'h10);
    step();
    check("both_done", {30'd0, lsu_state_all[1:0]}, 32'h3);
    check("both_out", lsu_out_all, 32'h0000_005A);
    check("both_no_wr", {28'd0, mem_write_valid}, 32'h0);
    rd_en = 1'b0; wr_en = 1'b0;
    update_phase();

    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
